// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS registers, a small transmit FIFO and a bit FSM.
// Define MMIO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        txd
);

    localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW     = PtrW + 1;
    localparam logic [15:0] BaudLast = 16'(CLKS_PER_BIT - 1);

`ifdef MMIO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e            state_q, state_d;
    logic [15:0]       baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;
    logic              overflow_q, overflow_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [7:0]        fifo_q [FIFO_DEPTH];
`ifdef MMIO_UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic       addr_hit, sel_data, sel_status;
    logic       full, empty, busy;
    logic       push_req, push, pop, baud_done;
    logic [7:0] head;
    logic       unused_bits;

    assign unused_bits = ^{WriteData[31:8], DataAdr[1:0]};

    // Register decode
    assign addr_hit   = (DataAdr[31:3] == BASE_ADDR[31:3]);
    assign sel_data   = addr_hit & ~DataAdr[2];
    assign sel_status = addr_hit & DataAdr[2];

    assign full      = (count_q == CntW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign busy      = (state_q != StIdle) | ~empty;
    assign head      = fifo_q[rd_ptr_q];
    assign baud_done = (baud_q == '0);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is then legal.
    assign push_req = MemWrite & sel_data;
    assign push     = push_req & (~full | pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + CntW'(push) - CntW'(pop);
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (MemWrite && sel_status) begin
            overflow_d = 1'b0;
        end else if (push_req && !push) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        pop       = 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                txd_d = 1'b1;
                if (!empty) pop = 1'b1;
            end
            StStart: begin
                if (baud_done) begin
                    state_d   = StData;
                    txd_d     = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = '0;
                    baud_d    = BaudLast;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            StData: begin
                if (baud_done) begin
                    baud_d = BaudLast;
                    if (bit_idx_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                        state_d = StParity;
                        txd_d   = parity_q;
`else
                        state_d = StStop;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            StParity: begin
                if (baud_done) begin
                    state_d = StStop;
                    txd_d   = 1'b1;
                    baud_d  = BaudLast;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`endif
            StStop: begin
                if (baud_done) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = StIdle;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                txd_d   = 1'b1;
            end
        endcase
        // Both IDLE and end-of-STOP start a frame the same way.
        if (pop) begin
            state_d = StStart;
            shift_d = head;
            txd_d   = 1'b0;
            baud_d  = BaudLast;
`ifdef MMIO_UART_TX_PARITY_EN
            parity_d = ^head;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
`ifdef MMIO_UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
`ifdef MMIO_UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else if (push) begin
            fifo_q[wr_ptr_q] <= WriteData[7:0];
        end
    end

    always_comb begin
        ReadData = '0;
        if (sel_status) begin
            ReadData[0]   = busy;
            ReadData[1]   = full;
            ReadData[2]   = empty;
            ReadData[3]   = overflow_q;
            ReadData[7:4] = 4'(count_q);
        end
    end

    assign txd = txd_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_mmio_uart_tx;

    localparam int unsigned Cpb  = 4;
    localparam logic [31:0] Base = 32'h0000_1000;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int Fl = 11;
    localparam logic [15:0] Pat55 = 16'h04AA;
    localparam logic [15:0] PatA5 = 16'h054A;
    localparam logic [15:0] Pat3C = 16'h0478;
`else
    localparam int Fl = 10;
    localparam logic [15:0] Pat55 = 16'h02AA;
    localparam logic [15:0] PatA5 = 16'h034A;
    localparam logic [15:0] Pat3C = 16'h0278;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        txd;

    int n_total = 0;
    int n_bad   = 0;
    logic        rx_en = 1'b1;
    logic [7:0]  rx_b;
    logic [7:0]  rx_q [$];
    logic [63:0] v1, v2;
    logic        saw_low;

    mmio_uart_tx #(
        .BASE_ADDR   (Base),
        .CLKS_PER_BIT(Cpb),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemWrite (MemWrite),
        .DataAdr  (DataAdr),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .txd      (txd)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Each period of the pattern held for Cpb samples, period 0 first.
    function automatic logic [63:0] expand(input logic [15:0] pat, input int nper);
        logic [63:0] v = '0;
        for (int p = 0; p < nper; p++)
            for (int c = 0; c < Cpb; c++) v[p*Cpb+c] = pat[p];
        return v;
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
    endtask

    task automatic idle();
        @(negedge clk);
        MemWrite = 1'b0;
        DataAdr  = Base + 32'h4;
        #1;
    endtask

    task automatic capture(input int n, input bit now, output logic [63:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            if (i > 0 || !now) @(negedge clk);
            v[i] = txd;
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        DataAdr = Base + 32'h4;
        #1;
        while (ReadData !== 32'h4 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq(tag, ReadData, 64'h4);
    endtask

    // Mid-bit sampling receiver feeding rx_q.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_en && reset === 1'b1 && txd === 1'b0) begin
                repeat (Cpb / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (Cpb) @(negedge clk);
                    rx_b[i] = txd;
                end
`ifdef MMIO_UART_TX_PARITY_EN
                repeat (Cpb) @(negedge clk);
                check_eq("rx_parity", txd, ^rx_b);
`endif
                repeat (Cpb) @(negedge clk);
                check_eq("rx_stop", txd, 1);
                rx_q.push_back(rx_b);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reset state and decode
        idle();
        check_eq("rst_status", ReadData, 64'h4);
        check_eq("rst_txd", txd, 1);
        DataAdr = Base + 32'h8;
        #1 check_eq("undecoded_read", ReadData, 0);
        DataAdr = Base;
        #1 check_eq("txdata_read", ReadData, 0);
        wr(Base + 32'h8, 32'h99);
        idle();
        check_eq("undecoded_write", ReadData, 64'h4);

        // Single frame 0x55
        wr(Base, 32'h55);
        idle();
        check_eq("push_txd_still_high", txd, 1);
        check_eq("push_status", ReadData, 64'h11);
        capture(Fl * Cpb, 1'b0, v1);
        check_eq("frame_55", v1, expand(Pat55, Fl));
        @(negedge clk);
        #1 check_eq("frame_55_end_status", ReadData, 64'h4);
        check_eq("frame_55_end_txd", txd, 1);

        // Overflow: six back-to-back stores
        rx_q.delete();
        for (int i = 1; i <= 6; i++) wr(Base, 32'(i));
        idle();
        check_eq("ovf_status", ReadData, 64'h4B);
        wr(Base + 32'h4, 32'h0);
        idle();
        check_eq("ovf_clear_status", ReadData, 64'h43);
        wait_idle("ovf_drain", 400);
        repeat (2) @(negedge clk);
        check_eq("ovf_rx_count", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            check_eq("ovf_rx_byte", rx_q[i], 64'(i + 1));

        // Two frames back to back, no idle gap
        rx_q.delete();
        wr(Base, 32'hA5);
        wr(Base, 32'h3C);
        idle();
        capture(Fl * Cpb, 1'b1, v1);
        capture(Fl * Cpb, 1'b0, v2);
        check_eq("b2b_frame_a5", v1, expand(PatA5, Fl));
        check_eq("b2b_frame_3c", v2, expand(Pat3C, Fl));
        wait_idle("b2b_drain", 100);
        repeat (2) @(negedge clk);
        check_eq("b2b_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check_eq("b2b_rx_0", rx_q[0], 64'hA5);
            check_eq("b2b_rx_1", rx_q[1], 64'h3C);
        end

        // Asynchronous reset during data bit 3
        rx_en = 1'b0;
        wr(Base, 32'h00);
        idle();
        repeat (18) @(negedge clk);
        check_eq("mid_frame_txd_low", txd, 0);
        #1 reset = 1'b0;
        #1 check_eq("async_rst_txd", txd, 1);
        check_eq("async_rst_status", ReadData, 64'h4);
        repeat (2) @(negedge clk);
        reset   = 1'b1;
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) saw_low = 1'b1;
        end
        check_eq("no_resume_txd", saw_low, 0);
        #1 check_eq("post_rst_status", ReadData, 64'h4);

`ifdef MMIO_UART_TX_PARITY_EN
        wr(Base, 32'h07);
        idle();
        capture(Fl * Cpb, 1'b0, v1);
        check_eq("parity_07", v1, expand(16'h060E, Fl));
        @(negedge clk);
        #1 check_eq("parity_07_end", ReadData, 64'h4);
        wr(Base, 32'h03);
        idle();
        capture(Fl * Cpb, 1'b0, v1);
        check_eq("parity_03", v1, expand(16'h0406, Fl));
        wait_idle("parity_drain", 100);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
